// File: rtl/wrport_rr_arbiter_if.sv
// Register-file write-port bundle shared by the requesters (master side)
// and the arbiter (slave side).
interface wrport_rr_arbiter_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
);
   logic [1:0]        req;
   logic [1:0]        lock;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] data0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] data1;
   logic [1:0]        gnt;
   logic              port_en;
   logic [ADDR_W-1:0] port_addr;
   logic [DATA_W-1:0] port_data;
   logic              busy;

   modport master (
      output req, lock, addr0, data0, addr1, data1,
      input  gnt, port_en, port_addr, port_data, busy
   );

   modport slave (
      input  req, lock, addr0, data0, addr1, data1,
      output gnt, port_en, port_addr, port_data, busy
   );
endinterface

// File: rtl/wrport_rr_arbiter.sv
// Two-requester round-robin arbiter for the register-file write port, with
// locked ownership bounded by MAX_HOLD. Define ARB_STATS_EN for grant counters.
module wrport_rr_arbiter #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   wrport_rr_arbiter_if.slave bus
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]       gnt_cnt0,
   output logic [15:0]       gnt_cnt1
`endif
);

   localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              last_q, last_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              own, oth;
   logic [1:0]        gnt;
   logic [1:0]        wr;
   logic [ADDR_W-1:0] addr_mux;
   logic [DATA_W-1:0] data_mux;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; reset is synchronous, so it lives inside the clocked branch.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
      end
   end

   // NOTE: every signal assigned here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      hold_d  = hold_q;
      own     = (state_q == GRANT1);
      oth     = ~own;
      unique case (state_q)
         IDLE: begin
            hold_d = '0;
            unique case (bus.req)
               2'b01:   state_d = GRANT0;
               2'b10:   state_d = GRANT1;
               2'b11:   state_d = last_q ? GRANT0 : GRANT1;
               default: state_d = IDLE;
            endcase
         end
         GRANT0, GRANT1: begin
            // Locked owner keeps the port until it has held it MAX_HOLD cycles
            // while the other side is waiting.
            if (bus.req[own] && bus.lock[own] && (hold_q < HOLD_LIM || !bus.req[oth])) begin
               if (hold_q < HOLD_LIM) hold_d = hold_q + HOLD_W'(1);
            end else if (bus.req[oth]) begin
               state_d = oth ? GRANT1 : GRANT0;
               last_d  = own;
               hold_d  = '0;
            end else if (bus.req[own]) begin
               hold_d = '0;
            end else begin
               state_d = IDLE;
               last_d  = own;
               hold_d  = '0;
            end
         end
         default: begin
            state_d = IDLE;
            hold_d  = '0;
         end
      endcase
   end

   always_comb begin
      gnt      = {state_q == GRANT1, state_q == GRANT0};
      wr       = gnt & bus.req;
      addr_mux = '0;
      data_mux = '0;
      unique case (gnt)
         2'b01: begin
            addr_mux = bus.addr0;
            data_mux = bus.data0;
         end
         2'b10: begin
            addr_mux = bus.addr1;
            data_mux = bus.data1;
         end
         default: ;
      endcase
   end

   assign bus.gnt       = gnt;
   assign bus.busy      = |gnt;
   assign bus.port_en   = |wr;
   assign bus.port_addr = addr_mux;
   assign bus.port_data = data_mux;

`ifdef ARB_STATS_EN
   logic [15:0] cnt0_q, cnt1_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (wr[0] && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
         if (wr[1] && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
      end
   end

   assign gnt_cnt0 = cnt0_q;
   assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_wrport_rr_arbiter.sv
// Directed self-checking bench for wrport_rr_arbiter (MAX_HOLD=4); the
// counter section is active when ARB_STATS_EN is defined.
module tb_wrport_rr_arbiter;

   localparam int DATA_W   = 64;
   localparam int ADDR_W   = 5;
   localparam int MAX_HOLD = 4;

   localparam logic [ADDR_W-1:0] A0 = 5'h03;
   localparam logic [ADDR_W-1:0] A1 = 5'h1C;
   localparam logic [DATA_W-1:0] D0 = 64'hA0A0_1111_2222_3333;
   localparam logic [DATA_W-1:0] D1 = 64'h5B5B_4444_5555_6666;

   logic clk;
   logic reset_n;
   int   n_assert = 0;
   int   n_fail   = 0;

   wrport_rr_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

`ifdef ARB_STATS_EN
   logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

   wrport_rr_arbiter #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .MAX_HOLD(MAX_HOLD)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
`ifdef ARB_STATS_EN
      ,
      .gnt_cnt0(gnt_cnt0),
      .gnt_cnt1(gnt_cnt1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] r, input logic [1:0] l);
      bus.req  = r;
      bus.lock = l;
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n   = 1'b0;
      bus.req   = 2'b00;
      bus.lock  = 2'b00;
      bus.addr0 = A0;
      bus.data0 = D0;
      bus.addr1 = A1;
      bus.data1 = D1;
      tick();
      tick();
      reset_n = 1'b1;
      #1;
      check("reset_gnt",  64'(bus.gnt), 64'd0);
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_en",   64'(bus.port_en), 64'd0);
      check("reset_data", bus.port_data, 64'd0);
      check("reset_addr", 64'(bus.port_addr), 64'd0);

      // Single requester 0, no lock
      drive(2'b01, 2'b00);
      check("r0_first_gnt", 64'(bus.gnt), 64'd0);
      check("r0_first_en",  64'(bus.port_en), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("r0_gnt",  64'(bus.gnt), 64'b01);
         check("r0_en",   64'(bus.port_en), 64'd1);
         check("r0_addr", 64'(bus.port_addr), 64'(A0));
         check("r0_data", bus.port_data, D0);
      end
      drive(2'b00, 2'b00);
      check("r0_drop_en", 64'(bus.port_en), 64'd0);
      tick();
      check("r0_idle_gnt",  64'(bus.gnt), 64'd0);
      check("r0_idle_busy", 64'(bus.busy), 64'd0);

      // Both requesting, no lock: alternate every cycle starting with 0
      do_reset();
      drive(2'b11, 2'b00);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("alt_gnt",  64'(bus.gnt), (i % 2 == 0) ? 64'b01 : 64'b10);
         check("alt_data", bus.port_data, (i % 2 == 0) ? D0 : D1);
         check("alt_addr", 64'(bus.port_addr), (i % 2 == 0) ? 64'(A0) : 64'(A1));
         check("alt_en",   64'(bus.port_en), 64'd1);
      end

      // Locked owner 0 with contention: exactly MAX_HOLD cycles, then 1 rotates in
      do_reset();
      drive(2'b11, 2'b01);
      for (int i = 0; i < MAX_HOLD; i++) begin
         tick();
         check("hold_gnt0", 64'(bus.gnt), 64'b01);
      end
      tick();
      check("hold_rot1", 64'(bus.gnt), 64'b10);
      check("hold_rot1_data", bus.port_data, D1);
      tick();
      check("hold_back0", 64'(bus.gnt), 64'b01);

      // Locked owner without contention keeps the port indefinitely
      do_reset();
      drive(2'b01, 2'b01);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("nocont_gnt", 64'(bus.gnt), 64'b01);
      end
      drive(2'b11, 2'b01);
      tick();
      check("nocont_preempt", 64'(bus.gnt), 64'b10);

      // lock on a non-requesting owner is ignored: the waiting side takes over
      drive(2'b01, 2'b10);
      tick();
      check("lock_noreq_gnt", 64'(bus.gnt), 64'b01);

      // Reset in the middle of requester 1 holding a lock
      drive(2'b11, 2'b10);
      tick();
      check("mid_gnt1", 64'(bus.gnt), 64'b10);
      reset_n = 1'b0;
      tick();
      check("mid_reset_gnt", 64'(bus.gnt), 64'd0);
      check("mid_reset_en",  64'(bus.port_en), 64'd0);
      reset_n = 1'b1;
      tick();
      check("post_reset_gnt", 64'(bus.gnt), 64'b01);

`ifdef ARB_STATS_EN
      // 5 writes from 0, 3 from 1, one granted cycle with req dropped
      do_reset();
      drive(2'b01, 2'b00);
      check("cnt_clear0", 64'(gnt_cnt0), 64'd0);
      check("cnt_clear1", 64'(gnt_cnt1), 64'd0);
      tick();
      tick();
      tick();
      drive(2'b11, 2'b00);
      tick();
      tick();
      tick();
      tick();
      tick();
      drive(2'b10, 2'b00);
      tick();
      check("cnt_pre_drop_gnt", 64'(bus.gnt), 64'b10);
      drive(2'b00, 2'b00);
      check("cnt_drop_en", 64'(bus.port_en), 64'd0);
      tick();
      check("cnt0", 64'(gnt_cnt0), 64'd5);
      check("cnt1", 64'(gnt_cnt1), 64'd3);
      do_reset();
      #1;
      check("cnt0_reset", 64'(gnt_cnt0), 64'd0);
      check("cnt1_reset", 64'(gnt_cnt1), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/wrport_rr_arbiter.md
Name: wrport_rr_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single register-file write port between requesters, e.g. writeback and a multi-cycle unit.
- Grants are registered and one-hot.
- Grant selects the winning requester's write address/data onto the port, with the 1:2 select encoded as gnt[1:0].
- Supports locked multi-cycle ownership, with a bounded hold to guarantee fairness.

Parameters:
- DATA_W, 64, write data width
- ADDR_W, 5, register address width
- MAX_HOLD, 4, max consecutive cycles one requester may own the port while the other is requesting (>=1)

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- req  input  2  req[i]: requester i wants the port this cycle
- lock  input  2  lock[i]: requester i wants to keep the grant next cycle (ignored unless req[i])
- addr0  input  ADDR_W  requester 0 write address
- data0  input  DATA_W  requester 0 write data
- addr1  input  ADDR_W  requester 1 write address
- data1  input  DATA_W  requester 1 write data
- gnt  output  2  registered one-hot grant, 2'b00 when idle
- port_en  output  1  write enable to register file
- port_addr  output  ADDR_W  muxed address
- port_data  output  DATA_W  muxed data
- busy  output  1  gnt != 0

Behaviour:
- Reset (clk edge with reset_n=0):
  - gnt=00, state=IDLE, last=1 (requester 0 wins first tie), hold_cnt=0.
  - reset_n dominates everything, including mid-lock; any grant is dropped the following cycle.
- Latency: request sampled at edge N, gnt valid after edge N (visible in cycle N+1). Grant changes only on clock edges.
- States:
  - IDLE:
    - req=00 -> stay.
    - One request -> grant it.
    - req=11 -> grant !last.
  - GRANT0 / GRANT1 (owner o, other p):
    - Keep: req[o]&lock[o] and (hold_cnt < MAX_HOLD-1 or !req[p]) -> stay, hold_cnt++ (saturates at MAX_HOLD-1).
    - Otherwise re-arbitrate:
      - req[p] -> switch to p, last=o, hold_cnt=0.
      - else req[o] -> stay, hold_cnt=0.
      - else -> IDLE, last=o, hold_cnt=0.
- Non-locked owner with both requesting always rotates. Back-to-back alternation gives 1 write/cycle with no bubble.
- Forced rotation: owner locked with other requesting is preempted after exactly MAX_HOLD consecutive granted cycles. The owner must tolerate this.
- Combinational outputs from registered gnt:
  - port_en = (gnt[0]&req[0]) | (gnt[1]&req[1]). A granted requester that drops req causes no write that cycle.
  - port_addr/port_data = fields of granted requester; zero when gnt=00.
- gnt never 11. Equivalent: never two writes per cycle.
- lock with req=0 has no effect.

Optional Feature:
- Macro ARB_STATS_EN:
  - Adds outputs gnt_cnt0, gnt_cnt1 (16 bits each).
  - Each increments on every cycle its port_en contribution is 1; saturates at 16'hFFFF; cleared by reset.
- Without the macro: ports and counters are absent; arbitration behaviour is identical.

Test Plan:
- Reset then req=01 for 3 cycles, lock=00 -> gnt=00 in first cycle, then 01 for each cycle; port_addr=addr0, port_en=1; req=00 -> gnt returns 00 next cycle.
- From IDLE after reset, req=11 constant, lock=00 -> gnt sequence 01,10,01,10; port_data alternates data0/data1 with no idle cycle.
- MAX_HOLD=4, req=11, lock=01 -> requester 0 holds gnt=01 for exactly 4 cycles, then gnt=10 for 1 cycle, then 01 again.
- req=01, lock=01 for 10 cycles, req[1]=0 -> gnt=01 throughout (no forced rotation without contention); assert req[1] at cycle 10 -> gnt=10 within MAX_HOLD cycles.
- Grant held on requester 1, deassert reset_n for one edge while req=11 -> gnt=00 next cycle; after release, requester 0 granted first (last=1).
- With ARB_STATS_EN, 5 writes from 0 and 3 from 1, including one granted cycle with req dropped -> gnt_cnt0=5, gnt_cnt1=3; reset clears both to 0.
